// File: rtl/dp_ram_param_if.sv
// Bus bundle for dp_ram_param: one write port, one read port and the
// read/write status returns. The master drives the requests; the slave
// (the RAM) drives the read data, qualifiers and the write error pulse.
//   wr_en/wr_addr/w_data/wr_be : write request, byte enables per 8 bits
//   rd_en/rd_addr              : read request
//   r_data/r_valid/r_err/r_uninit : read return and its qualifiers
//   wr_err                     : one-cycle out-of-range write pulse
interface dp_ram_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     w_data;
    logic [DATA_W/8-1:0]   wr_be;
    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;
    logic [DATA_W-1:0]     r_data;
    logic                  r_valid;
    logic                  r_err;
    logic                  r_uninit;
    logic                  wr_err;

    modport master (
        output wr_en, wr_addr, w_data, wr_be, rd_en, rd_addr,
        input  r_data, r_valid, r_err, r_uninit, wr_err
    );

    modport slave (
        input  wr_en, wr_addr, w_data, wr_be, rd_en, rd_addr,
        output r_data, r_valid, r_err, r_uninit, wr_err
    );
endinterface

// File: rtl/dp_ram_param.sv
// Parametrised simple dual-port RAM, single clock, with byte enables,
// selectable read/write collision behaviour, out-of-range flags and
// per-entry "never written" tracking.
//   clk : clock, everything on posedge
//   rst : asynchronous active-low reset (clears pipeline and written flags,
//         not the array)
//   bus : dp_ram_param_if slave modport (requests in, read return out)
// DATA_W must be a multiple of 8, 1 <= DEPTH <= 2**ADDR_W, RD_LAT is 1 or 2,
// WR_FIRST selects old-data (0) or bypassed new-data (1) on a collision.
module dp_ram_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 32,
    parameter int RD_LAT   = 1,
    parameter int WR_FIRST = 0
) (
    input  logic clk,
    input  logic rst,
    dp_ram_param_if.slave bus
);
    localparam int              NB      = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  written;

    logic              wr_in_range, rd_in_range, wr_hit;
    logic              flag_old, flag_eff;
    logic [ADDR_W-1:0] wr_idx, rd_idx;
    logic [DATA_W-1:0] old_word, merged_word, rd_word, rd_data_c;
    logic              rd_uninit_c;

    logic              s1_valid, s1_err, s1_uninit;
    logic [DATA_W-1:0] s1_data;

    logic              src_valid, src_err, src_uninit;
    logic [DATA_W-1:0] src_data;

    logic              r_valid_q, r_err_q, r_uninit_q, wr_err_q;
    logic [DATA_W-1:0] r_data_q;

    // Read-side lookup. Out-of-range addresses are steered to entry 0 so the
    // array is never indexed past its end; the result is masked anyway.
    always_comb begin
        wr_in_range = {1'b0, bus.wr_addr} < DEPTH_L;
        rd_in_range = {1'b0, bus.rd_addr} < DEPTH_L;
        wr_idx      = wr_in_range ? bus.wr_addr : '0;
        rd_idx      = rd_in_range ? bus.rd_addr : '0;
        old_word    = mem[rd_idx];
        flag_old    = written[rd_idx];
        wr_hit      = bus.wr_en && wr_in_range && (bus.wr_addr == bus.rd_addr);

        merged_word = old_word;
        for (int b = 0; b < NB; b++) begin
            if (bus.wr_be[b]) merged_word[8*b +: 8] = bus.w_data[8*b +: 8];
        end

        // Read-first needs nothing special: the array and flags still hold
        // their pre-write values when sampled at the colliding edge.
        if (WR_FIRST != 0 && wr_hit) begin
            rd_word  = merged_word;
            flag_eff = flag_old | (|bus.wr_be);
        end else begin
            rd_word  = old_word;
            flag_eff = flag_old;
        end

        // Never expose stale contents of an unwritten or out-of-range entry.
        rd_data_c   = (rd_in_range && flag_eff) ? rd_word : '0;
        rd_uninit_c = rd_in_range && !flag_eff;
    end

    // Source of the output register: the lookup itself for RD_LAT=1, the
    // extra pipeline stage for RD_LAT=2.
    always_comb begin
        if (RD_LAT == 1) begin
            src_valid  = bus.rd_en;
            src_data   = rd_data_c;
            src_err    = bus.rd_en && !rd_in_range;
            src_uninit = bus.rd_en && rd_uninit_c;
        end else begin
            src_valid  = s1_valid;
            src_data   = s1_data;
            src_err    = s1_err;
            src_uninit = s1_uninit;
        end
    end

    // Array has no reset.
    always_ff @(posedge clk) begin
        if (bus.wr_en && wr_in_range) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.wr_be[b]) mem[wr_idx][8*b +: 8] <= bus.w_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            written    <= '0;
            wr_err_q   <= 1'b0;
            s1_valid   <= 1'b0;
            s1_err     <= 1'b0;
            s1_uninit  <= 1'b0;
            s1_data    <= '0;
            r_valid_q  <= 1'b0;
            r_err_q    <= 1'b0;
            r_uninit_q <= 1'b0;
            r_data_q   <= '0;
        end else begin
            if (bus.wr_en && wr_in_range && (|bus.wr_be)) written[wr_idx] <= 1'b1;
            wr_err_q   <= bus.wr_en && !wr_in_range;

            s1_valid   <= bus.rd_en;
            s1_data    <= rd_data_c;
            s1_err     <= bus.rd_en && !rd_in_range;
            s1_uninit  <= bus.rd_en && rd_uninit_c;

            r_valid_q  <= src_valid;
            r_err_q    <= src_err;
            r_uninit_q <= src_uninit;
            if (src_valid) r_data_q <= src_data;   // hold last value otherwise
        end
    end

    assign bus.r_data   = r_data_q;
    assign bus.r_valid  = r_valid_q;
    assign bus.r_err    = r_err_q;
    assign bus.r_uninit = r_uninit_q;
    assign bus.wr_err   = wr_err_q;
endmodule

// File: tb/tb_dp_ram_param.sv
// Directed bench for dp_ram_param. Three instances cover the parameter
// corners: u0 defaults (8b x 32, RD_LAT=1, read-first), u1 16b x 20 deep
// write-first, u2 8b x 32 with RD_LAT=2. Each table row is one clock of
// stimulus for one instance; expected outputs are those seen after that edge.
module tb_dp_ram_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dp_ram_param_if #(.DATA_W(8),  .ADDR_W(5)) if0 ();
    dp_ram_param_if #(.DATA_W(16), .ADDR_W(5)) if1 ();
    dp_ram_param_if #(.DATA_W(8),  .ADDR_W(5)) if2 ();

    dp_ram_param #(.DATA_W(8), .ADDR_W(5), .DEPTH(32), .RD_LAT(1), .WR_FIRST(0))
        u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    dp_ram_param #(.DATA_W(16), .ADDR_W(5), .DEPTH(20), .RD_LAT(1), .WR_FIRST(1))
        u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    dp_ram_param #(.DATA_W(8), .ADDR_W(5), .DEPTH(32), .RD_LAT(2), .WR_FIRST(0))
        u2 (.clk(clk), .rst(rst), .bus(if2.slave));

    typedef struct {
        int          dut;
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [15:0] w_data;
        logic [1:0]  wr_be;
        logic        rd_en;
        logic [4:0]  rd_addr;
        logic        e_v;
        logic [15:0] e_d;
        logic        e_e;
        logic        e_u;
        logic        e_we;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(input int dut, input logic we, input logic [4:0] wa,
                                input logic [15:0] wd, input logic [1:0] be,
                                input logic re, input logic [4:0] ra,
                                input logic ev, input logic [15:0] ed,
                                input logic ee, input logic eu, input logic ewe);
        vec_t v;
        v.dut = dut; v.wr_en = we; v.wr_addr = wa; v.w_data = wd; v.wr_be = be;
        v.rd_en = re; v.rd_addr = ra; v.e_v = ev; v.e_d = ed; v.e_e = ee;
        v.e_u = eu; v.e_we = ewe;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_all();
        if0.wr_en = 0; if0.wr_addr = 0; if0.w_data = 0; if0.wr_be = 0; if0.rd_en = 0; if0.rd_addr = 0;
        if1.wr_en = 0; if1.wr_addr = 0; if1.w_data = 0; if1.wr_be = 0; if1.rd_en = 0; if1.rd_addr = 0;
        if2.wr_en = 0; if2.wr_addr = 0; if2.w_data = 0; if2.wr_be = 0; if2.rd_en = 0; if2.rd_addr = 0;
    endtask

    task automatic apply(input vec_t v);
        idle_all();
        case (v.dut)
            0: begin
                if0.wr_en = v.wr_en; if0.wr_addr = v.wr_addr; if0.w_data = v.w_data[7:0];
                if0.wr_be = v.wr_be[0]; if0.rd_en = v.rd_en; if0.rd_addr = v.rd_addr;
            end
            1: begin
                if1.wr_en = v.wr_en; if1.wr_addr = v.wr_addr; if1.w_data = v.w_data;
                if1.wr_be = v.wr_be; if1.rd_en = v.rd_en; if1.rd_addr = v.rd_addr;
            end
            default: begin
                if2.wr_en = v.wr_en; if2.wr_addr = v.wr_addr; if2.w_data = v.w_data[7:0];
                if2.wr_be = v.wr_be[0]; if2.rd_en = v.rd_en; if2.rd_addr = v.rd_addr;
            end
        endcase
    endtask

    task automatic check_outs(input int dut, input string tag, input logic ev,
                              input logic [15:0] ed, input logic ee, input logic eu,
                              input logic ewe);
        logic [15:0] d;
        logic v, e, u, we;
        case (dut)
            0:       begin d = {8'h0, if0.r_data}; v = if0.r_valid; e = if0.r_err; u = if0.r_uninit; we = if0.wr_err; end
            1:       begin d = if1.r_data;         v = if1.r_valid; e = if1.r_err; u = if1.r_uninit; we = if1.wr_err; end
            default: begin d = {8'h0, if2.r_data}; v = if2.r_valid; e = if2.r_err; u = if2.r_uninit; we = if2.wr_err; end
        endcase
        chk({tag, " r_valid"},  {15'h0, v},  {15'h0, ev});
        chk({tag, " r_data"},   d,           ed);
        chk({tag, " r_err"},    {15'h0, e},  {15'h0, ee});
        chk({tag, " r_uninit"}, {15'h0, u},  {15'h0, eu});
        chk({tag, " wr_err"},   {15'h0, we}, {15'h0, ewe});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //  dut we wa   wd        be     re ra   ev ed        ee eu we
        // u0: basic write/read, read-first collisions, wr_be=0
        add(0, 1, 3,  16'h00A5, 2'b01, 0, 0,  0, 16'h0000, 0, 0, 0);
        add(0, 0, 0,  16'h0000, 2'b00, 1, 3,  1, 16'h00A5, 0, 0, 0);
        add(0, 1, 5,  16'h0011, 2'b01, 0, 0,  0, 16'h00A5, 0, 0, 0);
        add(0, 1, 5,  16'h0022, 2'b01, 1, 5,  1, 16'h0011, 0, 0, 0);
        add(0, 0, 0,  16'h0000, 2'b00, 1, 5,  1, 16'h0022, 0, 0, 0);
        add(0, 0, 0,  16'h0000, 2'b00, 0, 0,  0, 16'h0022, 0, 0, 0);
        add(0, 1, 9,  16'h0033, 2'b01, 1, 9,  1, 16'h0000, 0, 1, 0);
        add(0, 0, 0,  16'h0000, 2'b00, 1, 9,  1, 16'h0033, 0, 0, 0);
        add(0, 1, 3,  16'h00FF, 2'b00, 0, 0,  0, 16'h0033, 0, 0, 0);
        add(0, 0, 0,  16'h0000, 2'b00, 1, 3,  1, 16'h00A5, 0, 0, 0);
        add(0, 1, 10, 16'h0044, 2'b00, 0, 0,  0, 16'h00A5, 0, 0, 0);
        add(0, 0, 0,  16'h0000, 2'b00, 1, 10, 1, 16'h0000, 0, 1, 0);
        // u1: byte enables, write-first collisions, out-of-range, unwritten
        add(1, 1, 7,  16'h1234, 2'b11, 0, 0,  0, 16'h0000, 0, 0, 0);
        add(1, 1, 7,  16'hABCD, 2'b01, 0, 0,  0, 16'h0000, 0, 0, 0);
        add(1, 0, 0,  16'h0000, 2'b00, 1, 7,  1, 16'h12CD, 0, 0, 0);
        add(1, 1, 5,  16'h0011, 2'b11, 0, 0,  0, 16'h12CD, 0, 0, 0);
        add(1, 1, 5,  16'h0022, 2'b01, 1, 5,  1, 16'h0022, 0, 0, 0);
        add(1, 0, 0,  16'h0000, 2'b00, 1, 5,  1, 16'h0022, 0, 0, 0);
        add(1, 1, 25, 16'hFFFF, 2'b11, 0, 0,  0, 16'h0022, 0, 0, 1);
        add(1, 0, 0,  16'h0000, 2'b00, 0, 0,  0, 16'h0022, 0, 0, 0);
        add(1, 0, 0,  16'h0000, 2'b00, 1, 25, 1, 16'h0000, 1, 0, 0);
        add(1, 0, 0,  16'h0000, 2'b00, 1, 2,  1, 16'h0000, 0, 1, 0);
        add(1, 1, 3,  16'h5555, 2'b00, 1, 3,  1, 16'h0000, 0, 1, 0);
        add(1, 1, 4,  16'hBEEF, 2'b11, 1, 4,  1, 16'hBEEF, 0, 0, 0);
        add(1, 0, 0,  16'h0000, 2'b00, 1, 5,  1, 16'h0022, 0, 0, 0);
        // u2: RD_LAT=2 back-to-back reads
        add(2, 1, 0,  16'h0010, 2'b01, 0, 0,  0, 16'h0000, 0, 0, 0);
        add(2, 1, 1,  16'h0011, 2'b01, 0, 0,  0, 16'h0000, 0, 0, 0);
        add(2, 1, 2,  16'h0012, 2'b01, 0, 0,  0, 16'h0000, 0, 0, 0);
        add(2, 1, 3,  16'h0013, 2'b01, 0, 0,  0, 16'h0000, 0, 0, 0);
        add(2, 0, 0,  16'h0000, 2'b00, 1, 0,  0, 16'h0000, 0, 0, 0);
        add(2, 0, 0,  16'h0000, 2'b00, 1, 1,  1, 16'h0010, 0, 0, 0);
        add(2, 0, 0,  16'h0000, 2'b00, 1, 2,  1, 16'h0011, 0, 0, 0);
        add(2, 0, 0,  16'h0000, 2'b00, 1, 3,  1, 16'h0012, 0, 0, 0);
        add(2, 0, 0,  16'h0000, 2'b00, 0, 0,  1, 16'h0013, 0, 0, 0);
        add(2, 0, 0,  16'h0000, 2'b00, 0, 0,  0, 16'h0013, 0, 0, 0);

        idle_all();
        #2 rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++)
            check_outs(d, $sformatf("reset u%0d", d), 0, 16'h0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            step();
            check_outs(tbl[i].dut, $sformatf("vec%0d", i), tbl[i].e_v, tbl[i].e_d,
                       tbl[i].e_e, tbl[i].e_u, tbl[i].e_we);
        end

        // Reset mid-stream on u2 with reads in flight.
        idle_all();
        if2.rd_en = 1; if2.rd_addr = 0;
        step();
        check_outs(2, "mid rd0", 0, 16'h0013, 0, 0, 0);
        if2.rd_addr = 1;
        step();
        check_outs(2, "mid rd1", 1, 16'h0010, 0, 0, 0);
        if2.rd_addr = 2;
        rst = 1'b0;
        #1;
        check_outs(2, "async rst", 0, 16'h0000, 0, 0, 0);
        step();
        if2.rd_en = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check_outs(2, $sformatf("post rst %0d", c), 0, 16'h0000, 0, 0, 0);
        end
        if2.rd_en = 1; if2.rd_addr = 2;
        step();
        if2.rd_en = 0;
        check_outs(2, "re-read lat1", 0, 16'h0000, 0, 0, 0);
        step();
        check_outs(2, "re-read uninit", 1, 16'h0000, 0, 1, 0);

        // Written flags on u0 are cleared too.
        if0.rd_en = 1; if0.rd_addr = 3;
        step();
        if0.rd_en = 0;
        check_outs(0, "u0 after rst", 1, 16'h0000, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
